// File: rtl/spart_fifo.sv
// spart_fifo: bus-programmable asynchronous serial port with TX/RX FIFOs,
// configurable character width, optional parity and sticky error flags.
module spart_fifo #(
  parameter int          DATA_BITS = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  localparam int W   = DATA_BITS;
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);
  localparam logic [2:0] LAST    = 3'(W - 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [15:0] div_q, div_d, div_eff, half;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        ovr_q, ovr_d, frm_q, frm_d, perr_q, perr_d;

  logic [W-1:0]   tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TAW:0]   tx_cnt_q, tx_cnt_d;
  logic [W-1:0]   rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RAW:0]   rx_cnt_q, rx_cnt_d;

  logic [2:0]   tx_st_q, tx_st_d, tx_bit_q, tx_bit_d;
  logic [15:0]  tx_tmr_q, tx_tmr_d;
  logic [W-1:0] tx_sh_q, tx_sh_d;
  logic         tx_pen_q, tx_pen_d, tx_par_q, tx_par_d, txd_q, txd_d;

  logic [2:0]   rx_st_q, rx_st_d, rx_bit_q, rx_bit_d;
  logic [15:0]  rx_tmr_q, rx_tmr_d;
  logic [W-1:0] rx_sh_q, rx_sh_d;
  logic         rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d, rx_pb_q, rx_pb_d;
  logic         rx_s1_q, rx_s2_q, rx_prev_q;

  logic wr, rd, clr, tx_push, tx_pop, rx_push, rx_pop;
  logic rx_done, rx_frm, rx_perr, tx_idle;
  logic [7:0] rdata;

  assign wr      = iocs & ~iorw;
  assign rd      = iocs & iorw;
  assign clr     = wr && ioaddr == 2'b01 && databus[7];
  assign tx_push = wr && ioaddr == 2'b00 && tx_cnt_q != TX_FULL;
  assign rx_pop  = rd && ioaddr == 2'b00 && rx_cnt_q != '0;
  assign rx_push = rx_done && rx_cnt_q != RX_FULL;
  assign databus = rd ? rdata : 8'bz;
  assign rda     = rx_cnt_q != '0;
  assign tbr     = tx_cnt_q != TX_FULL;
  assign txd     = txd_q;
  assign tx_idle = tx_st_q == S_IDLE && tx_cnt_q == '0;

  // Divisors below 3 are clamped; half is (DIV+1)/2 minus the load cycle.
  assign div_eff = (div_q < 16'd3) ? 16'd3 : div_q;
  assign half    = (div_eff >> 1) + {15'd0, div_eff[0]} - 16'd1;

  always_comb begin
    div_d  = div_q;
    ctrl_d = ctrl_q;
    ovr_d  = ovr_q & ~clr;
    frm_d  = frm_q & ~clr;
    perr_d = perr_q & ~clr;
    if (wr && ioaddr == 2'b01) ctrl_d = databus[1:0];
    if (wr && ioaddr == 2'b10) div_d[7:0] = databus;
    if (wr && ioaddr == 2'b11) div_d[15:8] = databus;
    if (rx_done && !rx_push) ovr_d = 1'b1;
    if (rx_frm) frm_d = 1'b1;
    if (rx_perr) perr_d = 1'b1;
  end

  always_comb begin
    tx_wp_d  = tx_wp_q + TAW'(tx_push);
    tx_rp_d  = tx_rp_q + TAW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
    rx_wp_d  = rx_wp_q + RAW'(rx_push);
    rx_rp_d  = rx_rp_q + RAW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
  end

  always_comb begin
    rdata = '0;
    unique case (ioaddr)
      2'b00:   if (rx_cnt_q != '0) rdata[W-1:0] = rx_mem_q[rx_rp_q];
      2'b01:   rdata = {2'b00, tx_idle, perr_q, frm_q, ovr_q, tbr, rda};
      2'b10:   rdata = div_q[7:0];
      default: rdata = div_q[15:8];
    endcase
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tmr_d = tx_tmr_q - 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pen_d = tx_pen_q;
    tx_par_d = tx_par_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      S_IDLE: begin
        tx_tmr_d = tx_tmr_q;
        tx_pop   = tx_cnt_q != '0;
      end
      S_START: if (tx_tmr_q == '0) begin
        tx_st_d  = S_DATA;
        tx_tmr_d = div_eff;
        tx_bit_d = '0;
        txd_d    = tx_sh_q[0];
      end
      S_DATA: if (tx_tmr_q == '0) begin
        tx_tmr_d = div_eff;
        if (tx_bit_q == LAST) begin
          tx_st_d = tx_pen_q ? S_PAR : S_STOP;
          txd_d   = tx_pen_q ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d  = tx_sh_q >> 1;
          txd_d    = tx_sh_q[1];
        end
      end
      S_PAR: if (tx_tmr_q == '0) begin
        tx_st_d  = S_STOP;
        tx_tmr_d = div_eff;
        txd_d    = 1'b1;
      end
      S_STOP: if (tx_tmr_q == '0) begin
        if (tx_cnt_q != '0) tx_pop = 1'b1;
        else tx_st_d = S_IDLE;
      end
      default: begin
        tx_st_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    if (tx_pop) begin
      tx_st_d  = S_START;
      tx_tmr_d = div_eff;
      tx_sh_d  = tx_mem_q[tx_rp_q];
      txd_d    = 1'b0;
      tx_pen_d = ctrl_q[0];
      tx_par_d = ^tx_mem_q[tx_rp_q] ^ ctrl_q[1];
    end
  end

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_tmr_d  = rx_tmr_q - 16'd1;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_pen_d  = rx_pen_q;
    rx_podd_d = rx_podd_q;
    rx_pb_d   = rx_pb_q;
    rx_done   = 1'b0;
    rx_frm    = 1'b0;
    rx_perr   = 1'b0;
    unique case (rx_st_q)
      S_IDLE: begin
        rx_tmr_d = half;
        if (rx_prev_q & ~rx_s2_q) begin
          rx_st_d   = S_START;
          rx_pen_d  = ctrl_q[0];
          rx_podd_d = ctrl_q[1];
        end
      end
      S_START: if (rx_tmr_q == '0) begin
        rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
        rx_tmr_d = div_eff;
        rx_bit_d = '0;
      end
      S_DATA: if (rx_tmr_q == '0) begin
        rx_tmr_d = div_eff;
        rx_sh_d  = {rx_s2_q, rx_sh_q[W-1:1]};
        if (rx_bit_q == LAST) rx_st_d = rx_pen_q ? S_PAR : S_STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      S_PAR: if (rx_tmr_q == '0) begin
        rx_pb_d  = rx_s2_q;
        rx_st_d  = S_STOP;
        rx_tmr_d = div_eff;
      end
      S_STOP: if (rx_tmr_q == '0) begin
        rx_st_d = S_IDLE;
        rx_done = 1'b1;
        rx_frm  = ~rx_s2_q;
        rx_perr = rx_pen_q & (rx_pb_q != (^rx_sh_q ^ rx_podd_q));
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= databus[W-1:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= DIV_RESET;
      ctrl_q    <= '0;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
      perr_q    <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      tx_st_q   <= S_IDLE;
      tx_tmr_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_pen_q  <= 1'b0;
      tx_par_q  <= 1'b0;
      txd_q     <= 1'b1;
      rx_st_q   <= S_IDLE;
      rx_tmr_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_pen_q  <= 1'b0;
      rx_podd_q <= 1'b0;
      rx_pb_q   <= 1'b0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      ctrl_q    <= ctrl_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
      perr_q    <= perr_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_st_q   <= tx_st_d;
      tx_tmr_q  <= tx_tmr_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_pen_q  <= tx_pen_d;
      tx_par_q  <= tx_par_d;
      txd_q     <= txd_d;
      rx_st_q   <= rx_st_d;
      rx_tmr_q  <= rx_tmr_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_pen_q  <= rx_pen_d;
      rx_podd_q <= rx_podd_d;
      rx_pb_q   <= rx_pb_d;
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end
endmodule
